// File: rtl/icache_ctrl_pkg.sv
// Shared types and helpers for the set-associative icache controller.
package icache_ctrl_pkg;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    FILL   = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // PLRU tree is stored heap-style: node 0 is the root, node i has
  // children 2i+1 (left) and 2i+2 (right).
  localparam int PLRU_ROOT = 0;

  function automatic int plru_left(input int node);
    return 2 * node + 1;
  endfunction

  function automatic int plru_right(input int node);
    return 2 * node + 2;
  endfunction

  // Width of a way index; never zero so a 1-way build still elaborates.
  function automatic int way_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Tree-PLRU: victim selection and MRU update for one set.
// A pointer bit of 0 steers to the left child. The root's left subtree
// holds the upper half of the ways; below the root, left is the lower
// way index. Equivalently, leaf position = way ^ (NUM_WAYS/2).
module icache_plru
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  localparam int WB = way_bits(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] plru_in,
  input  logic [WB-1:0]       access_way,
  output logic [WB-1:0]       victim,
  output logic [NUM_WAYS-2:0] plru_next
);

  localparam int LEVELS = $clog2(NUM_WAYS);
  localparam int HALF   = NUM_WAYS / 2;

  // Follow the pointer bits from the root down to a leaf.
  always_comb begin
    int          vnode;
    logic [WB-1:0] vleaf;
    vnode = PLRU_ROOT;
    vleaf = '0;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      vleaf[l] = plru_in[vnode];
      vnode    = plru_in[vnode] ? plru_right(vnode) : plru_left(vnode);
    end
    victim = vleaf ^ WB'(HALF);
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    int            unode;
    logic [WB-1:0] uleaf;
    uleaf     = access_way ^ WB'(HALF);
    unode     = PLRU_ROOT;
    plru_next = plru_in;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      plru_next[unode] = ~uleaf[l];
      unode            = uleaf[l] ? plru_right(unode) : plru_left(unode);
    end
  end

endmodule

// File: rtl/icache_ctrl_assoc.sv
// N-way set-associative instruction cache control FSM: hit/miss handling,
// victim-latched line fill and whole-cache flush sweep.
// Handshakes: mem_read and flush_req are levels held by the requester until
// mem_resp / flush_done; pmem_read is held by us until a one-cycle pmem_resp.
module icache_ctrl_assoc
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 16,
  parameter int SET_BITS = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                flush_req,
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [NUM_WAYS-2:0] plru_in,
  output logic                mem_resp,
  output logic                load_plru,
  output logic [NUM_WAYS-2:0] plru_next,
  output logic [NUM_WAYS-1:0] load_valid,
  output logic                set_valid,
  output logic [NUM_WAYS-1:0] load_tag,
  output logic [NUM_WAYS-1:0] data_we,
  output logic                data_in_sel,
  output logic                pmem_read,
  input  logic                pmem_resp,
  output logic                idx_sel,
  output logic [SET_BITS-1:0] flush_idx,
  output logic                flush_done
);

  localparam int WB = way_bits(NUM_WAYS);
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

  state_t              state_q, state_d;
  logic [WB-1:0]       victim_q, victim_d;
  logic [SET_BITS-1:0] cnt_q;

  logic [WB-1:0]       hit_way, free_way, plru_victim;
  logic                any_free;
  logic [NUM_WAYS-2:0] plru_upd;
  logic [NUM_WAYS-1:0] fill_onehot;

  // Lowest-index hit way and lowest-index invalid way of the set.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    any_free = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WB'(w);
      if (!valid_vec[w]) begin
        free_way = WB'(w);
        any_free = 1'b1;
      end
    end
  end

  icache_plru #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .plru_in    (plru_in),
    .access_way (hit_way),
    .victim     (plru_victim),
    .plru_next  (plru_upd)
  );

  // One-hot write enable for the latched fill victim.
  always_comb begin
    fill_onehot           = '0;
    fill_onehot[victim_q] = 1'b1;
  end

  // State, latched victim and flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOOKUP;
      victim_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (state_q == FLUSH) cnt_q <= (cnt_q == LAST_SET) ? '0 : cnt_q + 1'b1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    mem_resp    = 1'b0;
    load_plru   = 1'b0;
    plru_next   = '0;
    load_valid  = '0;
    set_valid   = 1'b0;
    load_tag    = '0;
    data_we     = '0;
    data_in_sel = 1'b0;
    pmem_read   = 1'b0;
    idx_sel     = 1'b0;
    flush_idx   = '0;
    flush_done  = 1'b0;
    unique case (state_q)
      LOOKUP: begin
        if (flush_req) begin
          state_d = FLUSH;
        end else if (mem_read) begin
          if (|hit_vec) begin
            mem_resp  = 1'b1;
            load_plru = 1'b1;
            plru_next = plru_upd;
          end else begin
            // Prefer an empty way so valid lines are not evicted needlessly.
            victim_d = any_free ? free_way : plru_victim;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        // The fill always completes; requests are re-evaluated in LOOKUP.
        pmem_read   = 1'b1;
        data_in_sel = 1'b1;
        if (pmem_resp) begin
          data_we    = fill_onehot;
          load_tag   = fill_onehot;
          load_valid = fill_onehot;
          set_valid  = 1'b1;
          state_d    = LOOKUP;
        end
      end
      FLUSH: begin
        idx_sel    = 1'b1;
        flush_idx  = cnt_q;
        load_valid = '1;
        load_plru  = 1'b1;
        if (cnt_q == LAST_SET) begin
          flush_done = 1'b1;
          state_d    = LOOKUP;
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl_assoc.sv
// Scoreboard bench for icache_ctrl_assoc (4 ways, 16 sets).
module tb_icache_ctrl_assoc;

  localparam int W  = 4;
  localparam int S  = 16;
  localparam int P  = W - 1;
  localparam int SB = $clog2(S);
  localparam int LV = $clog2(W);

  typedef struct packed {
    logic          mem_resp;
    logic          load_plru;
    logic [P-1:0]  plru_next;
    logic [W-1:0]  load_valid;
    logic          set_valid;
    logic [W-1:0]  load_tag;
    logic [W-1:0]  data_we;
    logic          data_in_sel;
    logic          pmem_read;
    logic          idx_sel;
    logic [SB-1:0] flush_idx;
    logic          flush_done;
  } out_t;
  localparam int OW = $bits(out_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read = 1'b0, flush_req = 1'b0, pmem_resp = 1'b0;
  logic [W-1:0] hit_vec = '0, valid_vec = '0;
  logic [P-1:0] plru_in = '0;
  logic mem_resp, load_plru, set_valid, data_in_sel, pmem_read, idx_sel, flush_done;
  logic [P-1:0] plru_next;
  logic [W-1:0] load_valid, load_tag, data_we;
  logic [SB-1:0] flush_idx;

  always #5 clk = ~clk;

  icache_ctrl_assoc #(.NUM_WAYS(W), .NUM_SETS(S)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .flush_req(flush_req),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .plru_in(plru_in),
    .mem_resp(mem_resp), .load_plru(load_plru), .plru_next(plru_next),
    .load_valid(load_valid), .set_valid(set_valid), .load_tag(load_tag),
    .data_we(data_we), .data_in_sel(data_in_sel), .pmem_read(pmem_read),
    .pmem_resp(pmem_resp), .idx_sel(idx_sel), .flush_idx(flush_idx),
    .flush_done(flush_done)
  );

  out_t act;
  assign act = {mem_resp, load_plru, plru_next, load_valid, set_valid, load_tag,
                data_we, data_in_sel, pmem_read, idx_sel, flush_idx, flush_done};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [OW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Path of each way from root to leaf, built bottom-up from heap leaves.
  // Leaf position p holds way p ^ (W/2); dir 1 = right child.
  int path_node[W][LV];
  int path_dir[W][LV];

  function automatic void build_paths();
    for (int p = 0; p < W; p++) begin
      int n;
      int way;
      n = (W - 1) + p;
      way = p ^ (W / 2);
      for (int l = 0; l < LV; l++) begin
        path_node[way][l] = (n - 1) / 2;
        path_dir[way][l]  = (n % 2 == 0) ? 1 : 0;
        n = (n - 1) / 2;
      end
    end
  endfunction

  function automatic logic [P-1:0] ref_touch(input logic [P-1:0] bits, input int way);
    for (int l = 0; l < LV; l++) bits[path_node[way][l]] = (path_dir[way][l] == 0);
    return bits;
  endfunction

  // The PLRU victim is the one way every node on its path points toward.
  function automatic int ref_plru_victim(input logic [P-1:0] bits);
    for (int w = 0; w < W; w++) begin
      bit ok;
      ok = 1'b1;
      for (int l = 0; l < LV; l++)
        if (int'(bits[path_node[w][l]]) != path_dir[w][l]) ok = 1'b0;
      if (ok) return w;
    end
    return -1;
  endfunction

  function automatic int ref_victim(input logic [W-1:0] vv, input logic [P-1:0] pi);
    for (int w = 0; w < W; w++) if (!vv[w]) return w;
    return ref_plru_victim(pi);
  endfunction

  function automatic int lowest_one(input logic [W-1:0] v);
    for (int w = 0; w < W; w++) if (v[w]) return w;
    return -1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== out_t'(e)) begin
        failures++;
        $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_now(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    return W'($urandom_range(0, 2**W - 1));
  endfunction

  function automatic logic [P-1:0] rnd_p();
    return P'($urandom_range(0, 2**P - 1));
  endfunction

  task automatic drive_push(input logic mr, input logic fr, input logic [W-1:0] hv,
                            input logic [W-1:0] vv, input logic [P-1:0] pi,
                            input logic pr, input out_t e);
    mem_read = mr; flush_req = fr; hit_vec = hv; valid_vec = vv;
    plru_in = pi; pmem_resp = pr;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_push(1'b0, 1'b0, rnd_w(), rnd_w(), rnd_p(), 1'b0, '0);
    tick();
  endtask

  task automatic apply_reset();
    mem_read = 1'b0; flush_req = 1'b0; pmem_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    check_now("reset_pmem_read", 32'(pmem_read), 32'd0);
    check_now("reset_outputs", 32'(act), 32'd0);
    exp_q.push_back('0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_hit(input logic [W-1:0] hv, input logic [P-1:0] pi);
    out_t e;
    e = '0;
    e.mem_resp  = 1'b1;
    e.load_plru = 1'b1;
    e.plru_next = ref_touch(pi, lowest_one(hv));
    drive_push(1'b1, 1'b0, hv, rnd_w(), pi, 1'b0, e);
    tick();
  endtask

  // Miss, fill after 'waits' idle pmem cycles, then re-lookup hit unless a
  // flush is pending. abort_at >= 0 resets the DUT at that wait cycle.
  task automatic do_miss(input logic [W-1:0] vv, input logic [P-1:0] pi, input int waits,
                         input logic fr_during, input int abort_at,
                         input logic [W-1:0] want_oh);
    out_t e;
    logic [W-1:0] oh;
    drive_push(1'b1, 1'b0, '0, vv, pi, 1'b0, '0);
    tick();
    oh = '0;
    oh[ref_victim(vv, pi)] = 1'b1;
    e = '0;
    e.pmem_read   = 1'b1;
    e.data_in_sel = 1'b1;
    for (int i = 0; i < waits; i++) begin
      if (i == abort_at) begin
        check_now("fill_pmem_read", 32'(pmem_read), 32'd1);
        apply_reset();
        return;
      end
      drive_push(1'($urandom_range(0, 1)), fr_during, rnd_w(), rnd_w(), rnd_p(), 1'b0, e);
      tick();
    end
    e.data_we    = oh;
    e.load_tag   = oh;
    e.load_valid = oh;
    e.set_valid  = 1'b1;
    drive_push(1'($urandom_range(0, 1)), fr_during, rnd_w(), rnd_w(), rnd_p(), 1'b1, e);
    #1;
    if (want_oh != '0) check_now("fill_onehot", 32'(data_we), 32'(want_oh));
    tick();
    if (!fr_during) do_hit(oh, rnd_p());
  endtask

  task automatic do_flush(input logic mr, input logic [W-1:0] hv, input int abort_at);
    out_t e;
    drive_push(mr, 1'b1, hv, rnd_w(), rnd_p(), 1'b0, '0);
    tick();
    for (int i = 0; i < S; i++) begin
      if (i == abort_at) begin
        apply_reset();
        return;
      end
      e = '0;
      e.idx_sel    = 1'b1;
      e.flush_idx  = SB'(i);
      e.load_valid = '1;
      e.load_plru  = 1'b1;
      e.flush_done = (i == S - 1);
      drive_push(1'($urandom_range(0, 1)), 1'b1, rnd_w(), rnd_w(), rnd_p(), 1'b0, e);
      tick();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    build_paths();
    #3;
    check_now("reset_state", 32'(act), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    idle();

    // Same-cycle hit with PLRU update.
    mem_read = 1'b1; hit_vec = 4'b0100; plru_in = 3'b000; valid_vec = 4'b1111;
    #1;
    check_now("hit_mem_resp", 32'(mem_resp), 32'd1);
    check_now("hit_plru_next", 32'(plru_next), 32'(3'b011));
    #1;
    do_hit(4'b0100, 3'b000);

    // Miss filling an invalid way, then a PLRU-victim miss.
    do_miss(4'b1011, rnd_p(), 5, 1'b0, -1, 4'b0100);
    do_miss(4'b1111, 3'b110, 2, 1'b0, -1, 4'b1000);
    idle();

    // Full flush, flush beating a hit, flush requested during a fill.
    do_flush(1'b0, '0, -1);
    do_flush(1'b1, 4'b0100, -1);
    do_miss(4'b1111, rnd_p(), 3, 1'b1, -1, '0);
    do_flush(1'b0, '0, -1);
    idle();

    // Reset aborting a fill and a flush; the next flush restarts at set 0.
    do_miss(4'b0111, rnd_p(), 6, 1'b0, 2, '0);
    idle();
    do_flush(1'b0, '0, 5);
    do_flush(1'b0, '0, -1);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 3) do_hit(W'($urandom_range(1, 2**W - 1)), rnd_p());
      else if (kind <= 6) do_miss(rnd_w(), rnd_p(), $urandom_range(0, 4), 1'b0, -1, '0);
      else if (kind == 7) do_flush(1'($urandom_range(0, 1)), rnd_w(), -1);
      else idle();
    end
    idle();
    mem_read = 1'b0; flush_req = 1'b0;
    @(posedge clk);
    #1;
    check_now("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_ctrl_assoc.md
# icache_ctrl_assoc

Parametrised control FSM for the N-way set-associative instruction cache; successor to the 2-way read-only controller. It sits between the fetch stage and the cache arrays (tag/valid/data/PLRU) plus the physical-memory port. It adds configurable associativity, tree-PLRU replacement with invalid-way preference, a latched victim during line fill, and a whole-cache flush sweep.

## Interface
- NUM_WAYS, 2, associativity; power of two, 2..8
- NUM_SETS, 16, sets per way; power of two
- SET_BITS, $clog2(NUM_SETS), flush index width
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  fetch request, held until mem_resp
- flush_req  in  1  invalidate-all request, held until flush_done
- hit_vec  in  NUM_WAYS  per-way tag-match & valid from datapath
- valid_vec  in  NUM_WAYS  valid bits of addressed set
- plru_in  in  NUM_WAYS-1  PLRU tree bits of addressed set
- mem_resp  out  1  fetch data valid (combinational with hit)
- load_plru  out  1  write plru_next into addressed set
- plru_next  out  NUM_WAYS-1  updated PLRU bits
- load_valid  out  NUM_WAYS  per-way valid write enable
- set_valid  out  1  value written to enabled valid bits
- load_tag  out  NUM_WAYS  per-way tag write enable
- data_we  out  NUM_WAYS  per-way full-line write enable
- data_in_sel  out  1  1 = data array input from pmem line
- pmem_read  out  1  line-fill request, held until pmem_resp
- pmem_resp  in  1  line-fill data valid, one-cycle pulse
- idx_sel  out  1  1 = array index from flush_idx
- flush_idx  out  SET_BITS  set being invalidated
- flush_done  out  1  one-cycle pulse, last flush cycle

## Operation
- States: LOOKUP, FILL, FLUSH. Reset -> LOOKUP.
- LOOKUP, flush_req=1: priority over mem_read; no mem_resp; -> FLUSH, counter=0.
- LOOKUP, mem_read=1, hit_vec!=0: mem_resp=1; load_plru=1; plru_next = tree update marking hit way MRU. Multi-hot hit_vec: lowest index way used. Stay LOOKUP.
- LOOKUP, mem_read=1, hit_vec=0: victim = lowest-index invalid way if any valid_vec bit is 0, else PLRU victim of plru_in; victim registered; -> FILL.
- FILL: pmem_read=1, data_in_sel=1. On pmem_resp: data_we, load_tag, load_valid one-hot at registered victim, set_valid=1; -> LOOKUP (next cycle re-lookup hits). No PLRU update on fill. mem_read deassertion or flush_req in FILL ignored; fill always completes.
- FLUSH: idx_sel=1; flush_idx=counter; load_valid=all ones, set_valid=0; load_plru=1, plru_next=0. Counter increments per cycle; at NUM_SETS-1: flush_done=1, counter wraps to 0, -> LOOKUP. mem_resp never asserted in FLUSH.
- PLRU tree: bit 0 root, children of node i at 2i+1/2i+2; bit=0 points victim left. Update sets path bits away from accessed way.
- LOOKUP with mem_read=0 and flush_req=0: all outputs 0.

## Timing
- Reset (async, rst_n=0): state LOOKUP, victim reg 0, counter 0; all outputs 0 while rst_n low and mem_read/flush_req low. Reset mid-FILL or mid-FLUSH aborts immediately; pmem_read drops asynchronously.
- Hit latency: 0 cycles (mem_resp same cycle as mem_read & hit).
- Miss latency: 1 (LOOKUP) + pmem wait cycles + 1 (pmem_resp cycle) + 1 (re-lookup) to mem_resp.
- Flush duration: exactly NUM_SETS cycles in FLUSH; flush_done on the NUM_SETS-th.
- pmem_read rises the cycle after the miss and falls the cycle after pmem_resp.

## Structure
- Package icache_ctrl_pkg: state enum, PLRU node indexing constants, width helpers.
- Sub-module icache_plru: combinational, NUM_WAYS param; inputs plru_in, access way; outputs victim way and updated bits. Instantiated once for victim and once for update (or shared).

## Test plan
- NUM_WAYS=4, mem_read, hit_vec=4'b0100, plru_in=3'b000 -> same-cycle mem_resp=1, load_plru=1, plru_next=3'b011.
- Miss, valid_vec=4'b1011 -> FILL next cycle, pmem_read=1; pmem_resp after 5 cycles -> data_we=load_tag=load_valid=4'b0100, set_valid=1; mem_resp on re-lookup hit.
- Miss, valid_vec=4'b1111, plru_in=3'b110 -> victim way 3, one-hot 4'b1000 on fill writes.
- flush_req with NUM_SETS=16 -> 16 FLUSH cycles, flush_idx 0..15, load_valid=4'b1111, set_valid=0, flush_done only at idx 15, back to LOOKUP.
- flush_req and mem_read with hit simultaneously in LOOKUP -> no mem_resp, FLUSH entered; flush_req asserted during FILL -> fill completes first, then FLUSH.
- rst_n low during FILL with pmem_read=1 -> pmem_read=0 immediately; after release, state LOOKUP, counter 0.
